// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer
//   Walks the camera configuration ROM from address 0 and turns every
//   {reg_addr, reg_data} entry into one SCCB register write. Entry FF_FF ends
//   the table; FF_xx inserts a pause of xx * TICK_CYCLES clocks.
//
// Ports
//   i_clk          clock
//   i_rstn         synchronous active-low reset
//   i_start        run request, honoured only in IDLE and DONE
//   o_busy         high from the cycle after an accepted start until DONE
//   o_done         high while in DONE
//   o_rom_addr     ROM address (ROM answers one cycle later on i_rom_data)
//   i_rom_data     ROM word
//   o_sccb_start   one-cycle write request to the SCCB master
//   o_sccb_addr    register address for the current write
//   o_sccb_data    register data for the current write
//   i_sccb_ready   SCCB master idle
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | after reset, waiting for i_start
// FETCH     | ROM read latency cycle
// DECODE    | classify i_rom_data: end marker, delay or register write
// ISSUE     | wait for master ready, pulse o_sccb_start
// WAIT_ACK  | wait for the master to drop ready
// WAIT_DONE | wait for the master to raise ready again
// DELAY     | count the delay down to zero
// DONE      | table finished, o_done high, waiting for a restart
module cam_cfg_sequencer #(
  parameter int TICK_CYCLES = 25000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_start,
  output logic [7:0]  o_sccb_addr,
  output logic [7:0]  o_sccb_data,
  input  logic        i_sccb_ready
);

  // Largest delay entry is FF_FE, i.e. 254 ticks.
  localparam int CNT_W = $clog2(254 * TICK_CYCLES + 1);
  localparam logic [CNT_W-1:0] TICK_W = CNT_W'(TICK_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    DELAY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       rom_addr_q, rom_addr_d;
  logic [7:0]       sccb_addr_q, sccb_addr_d;
  logic [7:0]       sccb_data_q, sccb_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             advance;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      sccb_addr_q <= '0;
      sccb_data_q <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      sccb_addr_q <= sccb_addr_d;
      sccb_data_q <= sccb_data_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    sccb_addr_d = sccb_addr_q;
    sccb_data_d = sccb_data_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    advance     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          rom_addr_d = '0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (i_rom_data == 16'hFFFF) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (i_rom_data[15:8] == 8'hFF) begin
          cnt_d   = CNT_W'(i_rom_data[7:0]) * TICK_W;
          state_d = DELAY;
        end else begin
          sccb_addr_d = i_rom_data[15:8];
          sccb_data_d = i_rom_data[7:0];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (i_sccb_ready) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!i_sccb_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_sccb_ready) advance = 1'b1;
      end
      DELAY: begin
        // The cycle that sees zero is spent here too, so xx ticks cost
        // xx * TICK_CYCLES + 1 cycles in this state.
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Shared step after a write or a delay; the address saturates at 255 so a
    // table without an end marker stops instead of wrapping.
    if (advance) begin
      if (rom_addr_q == 8'hFF) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end else begin
        rom_addr_d = rom_addr_q + 8'd1;
        state_d    = FETCH;
      end
    end
  end

  // The start pulse is qualified by the live ready input so it fires in the
  // very cycle the master is idle and can never fire while it is busy; it
  // lasts one cycle because ISSUE is left on that same edge.
  assign o_sccb_start = (state_q == ISSUE) && i_sccb_ready;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_rom_addr   = rom_addr_q;
  assign o_sccb_addr  = sccb_addr_q;
  assign o_sccb_data  = sccb_data_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
module tb_cam_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, sccb_start;
  logic [7:0]  rom_addr, sccb_addr, sccb_data;
  logic [15:0] rom_data = 16'h0000;
  logic        sccb_ready;

  logic [15:0] rom [256];
  logic        m_ready = 1'b1;
  int          m_cnt = 0;
  int          hold_cycles = 5;
  logic        bp_low = 1'b0;

  logic [15:0] log_q [$];
  int          viol = 0;
  logic        prev_start = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_cfg_sequencer #(.TICK_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_sccb_start (sccb_start),
    .o_sccb_addr  (sccb_addr),
    .o_sccb_data  (sccb_data),
    .i_sccb_ready (sccb_ready)
  );

  // ROM with a one-cycle registered read.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master: ready low for hold_cycles cycles after each start.
  assign sccb_ready = m_ready && !bp_low;
  always @(posedge clk) begin
    if (sccb_start) begin
      m_ready <= 1'b0;
      m_cnt   <= hold_cycles;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end
  end

  // Start-pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (sccb_start) begin
      log_q.push_back({sccb_addr, sccb_data});
      if (!sccb_ready) viol++;
      if (prev_start) viol++;
    end
    prev_start = sccb_start;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic wait_done(input string tag, input int max);
    int   n;
    logic pb;
    n  = 0;
    pb = 1'b0;
    while (!done && n < max) begin
      pb = busy;
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    if (n > 0) check({tag, "_busy_before"}, {31'd0, pb}, 32'd1);
  endtask

  // Starts the table and reports the cycle of the first start pulse
  // (cycle 0 = the cycle i_start is sampled); optionally re-pulses i_start.
  task automatic measure(input int pulse_at, output int first);
    first = -1;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (sccb_start && first < 0) first = c;
      if (pulse_at > 0 && c == pulse_at + 2) begin
        check("ign_start_busy", {31'd0, busy}, 32'd1);
        check("ign_start_addr", {24'd0, rom_addr}, 32'd0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int base, first, wrap, n, bad_start, bad_hold;
    logic [7:0] pa;

    // Reset state
    fill(16'hFFFF);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_start", {31'd0, sccb_start}, 32'd0);
    check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    check("rst_sccb_addr", {24'd0, sccb_addr}, 32'd0);
    check("rst_sccb_data", {24'd0, sccb_data}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic run
    rom[0] = 16'h1280; rom[1] = 16'h1180; rom[2] = 16'hFFFF;
    hold_cycles = 5;
    base = log_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c1_busy", {31'd0, busy}, 32'd1);
    check("c1_rom_addr", {24'd0, rom_addr}, 32'd0);
    @(negedge clk);
    check("c2_no_start", {31'd0, sccb_start}, 32'd0);
    @(negedge clk);
    check("c3_start", {31'd0, sccb_start}, 32'd1);
    check("c3_sccb_addr", {24'd0, sccb_addr}, 32'h12);
    check("c3_sccb_data", {24'd0, sccb_data}, 32'h80);
    wait_done("basic", 200);
    check("basic_pulses", log_q.size() - base, 32'd2);
    check("basic_w0", {16'd0, log_q[base]}, 32'h1280);
    check("basic_w1", {16'd0, log_q[base+1]}, 32'h1180);
    check("basic_end_addr", {24'd0, rom_addr}, 32'd2);

    // Backpressure, also restart from DONE
    fill(16'hFFFF);
    rom[0] = 16'h55AA;
    bp_low = 1'b1;
    base = log_q.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("restart_done_clr", {31'd0, done}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_addr", {24'd0, rom_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    bad_start = 0;
    bad_hold  = 0;
    for (int i = 0; i < 20; i++) begin
      if (sccb_start) bad_start++;
      if (sccb_addr != 8'h55 || sccb_data != 8'hAA) bad_hold++;
      @(negedge clk);
    end
    check("bp_no_start", bad_start, 32'd0);
    check("bp_stable", bad_hold, 32'd0);
    bp_low = 1'b0;
    #1;
    check("bp_release_start", {31'd0, sccb_start}, 32'd1);
    wait_done("bp", 100);
    check("bp_pulses", log_q.size() - base, 32'd1);
    check("bp_w0", {16'd0, log_q[base]}, 32'h55AA);

    // Delay of 3 ticks with an ignored i_start during the delay
    fill(16'hFFFF);
    rom[0] = 16'hFF03; rom[1] = 16'h3A04;
    base = log_q.size();
    measure(6, first);
    check("delay3_first_start", first, 32'd18);
    wait_done("delay3", 100);
    check("delay3_pulses", log_q.size() - base, 32'd1);
    check("delay3_w", {16'd0, log_q[base]}, 32'h3A04);

    // Zero-tick delay spends a single cycle in DELAY
    rom[0] = 16'hFF00;
    base = log_q.size();
    measure(-1, first);
    check("delay0_first_start", first, 32'd6);
    wait_done("delay0", 100);
    check("delay0_pulses", log_q.size() - base, 32'd1);

    // No end marker: 256 writes, address saturates at 255
    fill(16'h40D0);
    base = log_q.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wrap = 0;
    n = 0;
    pa = rom_addr;
    while (!done && n < 6000) begin
      @(negedge clk);
      if (rom_addr < pa) wrap++;
      pa = rom_addr;
      n++;
    end
    check("noend_done", {31'd0, done}, 32'd1);
    check("noend_pulses", log_q.size() - base, 32'd256);
    check("noend_addr", {24'd0, rom_addr}, 32'd255);
    check("noend_wrap", wrap, 32'd0);

    // Reset during WAIT_DONE of entry 1
    fill(16'hFFFF);
    rom[0] = 16'h1280; rom[1] = 16'h1180;
    hold_cycles = 10;
    base = log_q.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (log_q.size() < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rm_second_pulse", log_q.size() - base, 32'd2);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_done", {31'd0, done}, 32'd0);
    check("rm_start", {31'd0, sccb_start}, 32'd0);
    check("rm_rom_addr", {24'd0, rom_addr}, 32'd0);
    check("rm_sccb_addr", {24'd0, sccb_addr}, 32'd0);
    check("rm_sccb_data", {24'd0, sccb_data}, 32'd0);
    repeat (30) @(negedge clk);
    check("rm_no_pulse", log_q.size() - base, 32'd2);
    base = log_q.size();
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("rm_restart_addr", {24'd0, rom_addr}, 32'd0);
    check("rm_restart_busy", {31'd0, busy}, 32'd1);
    wait_done("rm", 200);
    check("rm_restart_pulses", log_q.size() - base, 32'd2);
    check("rm_restart_w0", {16'd0, log_q[base]}, 32'h1280);

    check("handshake_rules", viol, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
